sm_decode: RTL and testbench

SM_DECODE -- requirements
Module: sm_decode

---
 rtl/sm_pkg.sv | 17 +
 rtl/sm_decode_if.sv | 25 ++
 rtl/sm_decode_nib_neg.sv | 18 +
 rtl/sm_decode.sv | 123 ++++++++++++
 tb/tb_sm_decode.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/sm_pkg.sv
// rtl/sm_pkg.sv - shared types and constants for the sm_decode nibble-serial converter
package sm_pkg;

  localparam int NIBBLES = 4;
  localparam int NIB_W   = 4;

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Saturated magnitude 0x7FFF, emitted least-significant nibble first.
  function automatic logic [NIB_W-1:0] sat_nib(input logic last);
    return last ? 4'h7 : 4'hF;
  endfunction

endpackage

// File: rtl/sm_decode_if.sv
// rtl/sm_decode_if.sv - nibble stream bundle between source, sm_decode and sink
interface sm_decode_if;
  import sm_pkg::*;

  logic [NIB_W-1:0] in_nib;
  logic             in_valid;
  logic             in_ready;
  logic [NIB_W-1:0] out_nib;
  logic             out_sign;
  logic             out_last;
  logic             out_ovf;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  in_nib, in_valid, out_ready,
    output in_ready, out_nib, out_sign, out_last, out_ovf, out_valid
  );

  modport master (
    output in_nib, in_valid, out_ready,
    input  in_ready, out_nib, out_sign, out_last, out_ovf, out_valid
  );

endinterface

// File: rtl/sm_decode_nib_neg.sv
// rtl/sm_decode_nib_neg.sv - one nibble of a chained conditional two's-complement negation
module nib_neg
  import sm_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  input  logic             neg,
  input  logic             cin,
  output logic [NIB_W-1:0] res,
  output logic             cout
);

  always_comb begin
    res  = neg ? (~nib + {{(NIB_W-1){1'b0}}, cin}) : nib;
    // The +1 only ripples past a nibble whose inverted value is all ones.
    cout = cin & (nib == '0);
  end

endmodule

// File: rtl/sm_decode.sv
// rtl/sm_decode.sv - two's-complement to sign-magnitude converter on 4-bit nibble streams
// Optional saturation of 0x8000 to 0x7FFF is enabled by defining SM_DECODE_SAT_EN.
module sm_decode
  import sm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  sm_decode_if.slave  bus
);

  state_t           state;
  logic [1:0]       cnt;
  logic             carry;
  logic             sign;
  logic             ovf;
  logic [NIB_W-1:0] nib_buf [NIBBLES];

  logic             loading;
  logic             in_fire;
  logic             out_fire;
  logic [1:0]       cnt_nxt;
  logic [1:0]       sel_idx;
  logic [NIB_W-1:0] sel_nib;
  logic             sel_neg;
  logic             sel_cin;
  logic [NIB_W-1:0] neg_res;
  logic             neg_cout;
  logic             word_ovf;
  logic [NIB_W-1:0] first_nib;
  logic [NIB_W-1:0] next_nib;

  assign loading  = (state == LOAD);
  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;
  assign cnt_nxt  = cnt + 2'd1;

  // The negator always prepares the nibble to be shown next: slot 0 while the
  // last input nibble arrives, slot cnt+1 while emitting. carry therefore holds
  // the carry into the slot after the one currently on out_nib.
  assign sel_idx = loading ? 2'd0 : cnt_nxt;
  assign sel_nib = nib_buf[sel_idx];
  assign sel_neg = loading ? bus.in_nib[NIB_W-1] : sign;
  assign sel_cin = loading ? 1'b1 : carry;

  nib_neg u_nib_neg (
    .nib  (sel_nib),
    .neg  (sel_neg),
    .cin  (sel_cin),
    .res  (neg_res),
    .cout (neg_cout)
  );

  assign word_ovf = (nib_buf[0] == '0) && (nib_buf[1] == '0) &&
                    (nib_buf[2] == '0) && (bus.in_nib == 4'h8);

`ifdef SM_DECODE_SAT_EN
  assign first_nib = word_ovf ? sat_nib(1'b0) : neg_res;
  assign next_nib  = ovf ? sat_nib(cnt_nxt == 2'd3) : neg_res;
`else
  assign first_nib = neg_res;
  assign next_nib  = neg_res;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= LOAD;
      cnt           <= 2'd0;
      carry         <= 1'b1;
      sign          <= 1'b0;
      ovf           <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_nib   <= '0;
      bus.out_sign  <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_ovf   <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_fire) begin
            nib_buf[cnt] <= bus.in_nib;
            cnt          <= cnt_nxt;
            if (cnt == 2'd3) begin
              state         <= EMIT;
              sign          <= bus.in_nib[NIB_W-1];
              ovf           <= word_ovf;
              carry         <= neg_cout;
              bus.in_ready  <= 1'b0;
              bus.out_valid <= 1'b1;
              bus.out_nib   <= first_nib;
              bus.out_sign  <= bus.in_nib[NIB_W-1];
              bus.out_ovf   <= word_ovf;
              bus.out_last  <= 1'b0;
            end
          end
        end
        EMIT: begin
          if (out_fire) begin
            cnt <= cnt_nxt;
            if (cnt == 2'd3) begin
              state         <= LOAD;
              carry         <= 1'b1;
              sign          <= 1'b0;
              ovf           <= 1'b0;
              bus.in_ready  <= 1'b1;
              bus.out_valid <= 1'b0;
              bus.out_nib   <= '0;
              bus.out_sign  <= 1'b0;
              bus.out_ovf   <= 1'b0;
              bus.out_last  <= 1'b0;
            end else begin
              carry        <= neg_cout;
              bus.out_nib  <= next_nib;
              bus.out_last <= (cnt_nxt == 2'd3);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_decode.sv
// tb/tb_sm_decode.sv - self-checking bench for sm_decode (directed table, hand sequences, random words)
module tb_sm_decode;

  typedef struct {
    logic [15:0] word;
    logic [15:0] mag;
    logic        sign;
    logic        ovf;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  sm_decode_if bus ();

  sm_decode dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: integer value of the word, absolute value, truncated to 16 bits.
  function automatic logic [15:0] ref_mag(input logic [15:0] w);
    int v;
    int m;
    v = w[15] ? (int'(w) - 65536) : int'(w);
    m = (v < 0) ? -v : v;
`ifdef SM_DECODE_SAT_EN
    if (m > 32767) m = 32767;
`endif
    return 16'(m);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_nib"},   32'(bus.out_nib),   32'd0);
    chk({tag, "_out_sign"},  32'(bus.out_sign),  32'd0);
    chk({tag, "_out_last"},  32'(bus.out_last),  32'd0);
    chk({tag, "_out_ovf"},   32'(bus.out_ovf),   32'd0);
  endtask

  // Drives the first n nibbles of w back to back; the block is expected to be in LOAD.
  task automatic push_nibbles(input logic [15:0] w, input int n);
    for (int k = 0; k < n; k++) begin
      bus.in_valid = 1'b1;
      bus.in_nib   = w[k*4 +: 4];
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  // Full word: load with optional random gaps, then drain with optional random
  // backpressure; hold_at forces out_ready=0 for 3 cycles before that output slot.
  task automatic run_word(input string tag, input logic [15:0] w, input logic [15:0] mag,
                          input logic sign, input logic ovf, input bit rnd, input int hold_at);
    int  k;
    int  j;
    int  cyc;
    int  held;
    bit  fire;
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 200) begin
      chk({tag, "_load_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_load_out_nib"},   32'(bus.out_nib),   32'd0);
      bus.in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_nib   = w[k*4 +: 4];
      fire = bus.in_valid && bus.in_ready;
      tick();
      if (fire) k++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk({tag, "_load_timeout"}, 32'(k), 32'd4);
    j = 0;
    cyc = 0;
    held = 0;
    while (j < 4 && cyc < 200) begin
      if (j == hold_at && held < 3) begin
        bus.out_ready = 1'b0;
        held++;
      end else begin
        bus.out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
      chk({tag, "_out_nib"},   32'(bus.out_nib),   32'(mag[j*4 +: 4]));
      chk({tag, "_out_sign"},  32'(bus.out_sign),  32'(sign));
      chk({tag, "_out_ovf"},   32'(bus.out_ovf),   32'(ovf));
      chk({tag, "_out_last"},  32'(bus.out_last),  32'(j == 3));
      fire = bus.out_valid && bus.out_ready;
      tick();
      if (fire) j++;
      cyc++;
    end
    bus.out_ready = 1'b0;
    chk({tag, "_emit_timeout"}, 32'(j), 32'd4);
    chk({tag, "_done_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_done_in_ready"},  32'(bus.in_ready),  32'd1);
  endtask

  vec_t tab [8];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_nib    = 4'h0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset");

    tab[0] = '{16'h1234, 16'h1234, 1'b0, 1'b0};
    tab[1] = '{16'hFFFE, 16'h0002, 1'b1, 1'b0};
    tab[2] = '{16'hFF00, 16'h0100, 1'b1, 1'b0};
`ifdef SM_DECODE_SAT_EN
    tab[3] = '{16'h8000, 16'h7FFF, 1'b1, 1'b1};
`else
    tab[3] = '{16'h8000, 16'h8000, 1'b1, 1'b1};
`endif
    tab[4] = '{16'h0001, 16'h0001, 1'b0, 1'b0};
    tab[5] = '{16'h0000, 16'h0000, 1'b0, 1'b0};
    tab[6] = '{16'h7FFF, 16'h7FFF, 1'b0, 1'b0};
    tab[7] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0};

    for (int i = 0; i < 8; i++)
      run_word($sformatf("tab%0d", i), tab[i].word, tab[i].mag, tab[i].sign, tab[i].ovf, 1'b0, -1);

    // Output stalled on the second nibble of 0xFFFE.
    run_word("bp", 16'hFFFE, 16'h0002, 1'b1, 1'b0, 1'b0, 1);

    // Reset after two input nibbles, then a clean word.
    push_nibbles(16'h5678, 2);
    pulse_reset();
    check_idle("rst_load");
    run_word("after_rst_load", 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, -1);

    // Reset while emitting: nothing more may come out.
    push_nibbles(16'hFF00, 4);
    bus.out_ready = 1'b1;
    tick();
    pulse_reset();
    check_idle("rst_emit");
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("rst_emit_quiet", 32'(bus.out_valid), 32'd0);
    end
    bus.out_ready = 1'b0;
    run_word("after_rst_emit", 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, -1);

    for (int i = 0; i < 60; i++) begin
      logic [15:0] w;
      case ($urandom_range(0, 7))
        0:       w = 16'h8000;
        1:       w = {4'($urandom_range(8, 15)), 12'h000};
        2:       w = {8'($urandom), 8'h00};
        default: w = 16'($urandom);
      endcase
      run_word($sformatf("rnd%0d_%04h", i, w), w, ref_mag(w), w[15], (w == 16'h8000), 1'b1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
